axi_sram_slave: RTL and testbench

- AXI3 slave responder; the far end of the CPU's AXI master port. It terminates AR/R/AW/W/B and drives a single-port synchronous SRAM (1-cycle read latency).
- Used as the simulation/FPGA main memory behind the SoC crossbar for CPU bring-up.
- One transaction in flight at a time, reads and writes arbitrated round-robin.

---
 rtl/axi_pkg.sv | 29 ++
 rtl/axi_burst_addr_gen.sv | 18 +
 rtl/axi_sram_slave.sv | 177 +++++++++++++++++
 tb/tb_axi_sram_slave.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI3 widths, burst/response encodings and request record
package axi_pkg;

    localparam int AXI_ID_W  = 4;
    localparam int AXI_LEN_W = 4;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_e;

    typedef struct packed {
        logic [AXI_ID_W-1:0]  id;
        logic [31:0]          addr;
        logic [AXI_LEN_W-1:0] len;
        logic [2:0]           size;
        logic [1:0]           burst;
    } axi_req_t;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// rtl/axi_burst_addr_gen.sv - next beat address; WRAP and reserved bursts advance like INCR
module axi_burst_addr_gen
    import axi_pkg::*;
(
    input  logic [31:0] addr,
    input  logic [2:0]  size,
    input  logic [1:0]  burst,
    output logic [31:0] next_addr
);

    always_comb begin
        next_addr = addr;
        if (burst != BURST_FIXED) begin
            next_addr = addr + (32'd1 << size);
        end
    end

endmodule

// File: rtl/axi_sram_slave.sv
// rtl/axi_sram_slave.sv - single-outstanding AXI3 slave in front of a 1-cycle SRAM
// Optional macro AXI_SRAM_SLV_RANGE_CHECK_EN answers out-of-window bursts with SLVERR.
module axi_sram_slave
    import axi_pkg::*;
#(
    parameter int          MEM_AW    = 16,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic [AXI_ID_W-1:0]  arid,
    input  logic [31:0]          araddr,
    input  logic [AXI_LEN_W-1:0] arlen,
    input  logic [2:0]           arsize,
    input  logic [1:0]           arburst,
    input  logic                 arvalid,
    output logic                 arready,
    output logic [AXI_ID_W-1:0]  rid,
    output logic [31:0]          rdata,
    output logic [1:0]           rresp,
    output logic                 rlast,
    output logic                 rvalid,
    input  logic                 rready,
    input  logic [AXI_ID_W-1:0]  awid,
    input  logic [31:0]          awaddr,
    input  logic [AXI_LEN_W-1:0] awlen,
    input  logic [2:0]           awsize,
    input  logic [1:0]           awburst,
    input  logic                 awvalid,
    output logic                 awready,
    input  logic [AXI_ID_W-1:0]  wid,
    input  logic [31:0]          wdata,
    input  logic [3:0]           wstrb,
    input  logic                 wlast,
    input  logic                 wvalid,
    output logic                 wready,
    output logic [AXI_ID_W-1:0]  bid,
    output logic [1:0]           bresp,
    output logic                 bvalid,
    input  logic                 bready,
    output logic                 sram_en,
    output logic [3:0]           sram_we,
    output logic [MEM_AW-1:0]    sram_addr,
    output logic [31:0]          sram_wdata,
    input  logic [31:0]          sram_rdata
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RD_REQ  = 3'd1;
    localparam logic [2:0] ST_RD_CAP  = 3'd2;
    localparam logic [2:0] ST_RD_DATA = 3'd3;
    localparam logic [2:0] ST_WR_DATA = 3'd4;
    localparam logic [2:0] ST_WR_RESP = 3'd5;

    logic [2:0]           state;
    axi_req_t             req;
    logic [AXI_LEN_W-1:0] beat;
    logic                 prio_wr;
    logic                 err;
    logic [31:0]          rdata_q;

    logic        grant_rd;
    logic        grant_wr;
    logic        last_beat;
    logic        w_fire;
    logic        range_err;
    logic [31:0] next_addr;
    logic [31:0] offset;
    logic [31:0] start_offset;
    logic        unused_bits;

    // prio_wr remembers that the last grant went to the read side
    assign grant_rd  = arvalid && (!awvalid || !prio_wr);
    assign grant_wr  = awvalid && !grant_rd;
    assign arready   = (state == ST_IDLE) && grant_rd;
    assign awready   = (state == ST_IDLE) && grant_wr;

    assign last_beat = (beat == req.len);
    assign w_fire    = (state == ST_WR_DATA) && wvalid;

    assign offset       = req.addr - BASE_ADDR;
    assign start_offset = (grant_rd ? araddr : awaddr) - BASE_ADDR;

`ifdef AXI_SRAM_SLV_RANGE_CHECK_EN
    assign range_err = |start_offset[31:MEM_AW+2];
`else
    assign range_err = 1'b0;
`endif

    assign unused_bits = &{1'b0, wid, wlast, offset[1:0], offset[31:MEM_AW+2], start_offset};

    axi_burst_addr_gen u_addr_gen (
        .addr      (req.addr),
        .size      (req.size),
        .burst     (req.burst),
        .next_addr (next_addr)
    );

    assign sram_en    = !err && ((state == ST_RD_REQ) || w_fire);
    assign sram_we    = (!err && w_fire) ? wstrb : 4'b0000;
    assign sram_addr  = offset[MEM_AW+1:2];
    assign sram_wdata = wdata;

    assign rvalid = (state == ST_RD_DATA);
    assign rlast  = rvalid && last_beat;
    assign rid    = req.id;
    assign rdata  = rdata_q;
    assign rresp  = (rvalid && err) ? RESP_SLVERR : RESP_OKAY;

    assign wready = (state == ST_WR_DATA);
    assign bvalid = (state == ST_WR_RESP);
    assign bid    = req.id;
    assign bresp  = (bvalid && err) ? RESP_SLVERR : RESP_OKAY;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state   <= ST_IDLE;
            req     <= '0;
            beat    <= '0;
            prio_wr <= 1'b0;
            err     <= 1'b0;
            rdata_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_rd) begin
                        req     <= '{id: arid, addr: araddr, len: arlen, size: arsize, burst: arburst};
                        beat    <= '0;
                        err     <= range_err;
                        prio_wr <= 1'b1;
                        state   <= ST_RD_REQ;
                    end else if (grant_wr) begin
                        req     <= '{id: awid, addr: awaddr, len: awlen, size: awsize, burst: awburst};
                        beat    <= '0;
                        err     <= range_err;
                        prio_wr <= 1'b0;
                        state   <= ST_WR_DATA;
                    end
                end
                ST_RD_REQ: state <= ST_RD_CAP;
                ST_RD_CAP: begin
                    rdata_q <= err ? 32'h0 : sram_rdata;
                    state   <= ST_RD_DATA;
                end
                ST_RD_DATA: begin
                    if (rready) begin
                        if (last_beat) begin
                            state <= ST_IDLE;
                        end else begin
                            req.addr <= next_addr;
                            beat     <= beat + 1'b1;
                            state    <= ST_RD_REQ;
                        end
                    end
                end
                // the beat count alone ends a write burst; wlast is not trusted
                ST_WR_DATA: begin
                    if (wvalid) begin
                        req.addr <= next_addr;
                        if (last_beat) begin
                            state <= ST_WR_RESP;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                end
                ST_WR_RESP: begin
                    if (bready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
// tb/tb_axi_sram_slave.sv - scoreboard bench for axi_sram_slave with an SRAM device model
module tb_axi_sram_slave;

    localparam int          MEM_AW = 16;
    localparam logic [31:0] BASE   = 32'h0000_0000;
`ifdef AXI_SRAM_SLV_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic aclk, aresetn;
    logic [3:0] arid, rid, awid, wid, bid;
    logic [31:0] araddr, awaddr, rdata, wdata, sram_wdata, sram_rdata;
    logic [3:0] arlen, awlen, wstrb, sram_we;
    logic [2:0] arsize, awsize;
    logic [1:0] arburst, awburst, rresp, bresp;
    logic arvalid, arready, rlast, rvalid, rready;
    logic awvalid, awready, wlast, wvalid, wready, bvalid, bready, sram_en;
    logic [MEM_AW-1:0] sram_addr;

    axi_sram_slave #(.MEM_AW(MEM_AW), .BASE_ADDR(BASE)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // SRAM device the DUT drives
    logic [31:0] sram_mem [int];
    logic [31:0] sram_cur;
    always @(posedge aclk) begin
        if (sram_en) begin
            sram_cur = sram_mem.exists(int'(sram_addr)) ? sram_mem[int'(sram_addr)] : 32'h0;
            if (sram_we == 4'b0000) begin
                sram_rdata <= sram_cur;
            end else begin
                for (int b = 0; b < 4; b++)
                    if (sram_we[b]) sram_cur[8*b +: 8] = sram_wdata[8*b +: 8];
                sram_mem[int'(sram_addr)] = sram_cur;
            end
        end
    end

    typedef struct packed { logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; } r_exp_t;
    typedef struct packed { logic [3:0] id; logic [1:0] resp; } b_exp_t;
    typedef struct packed { logic [3:0] we; logic [MEM_AW-1:0] addr; logic [31:0] wdata; } s_exp_t;

    r_exp_t rq[$];
    b_exp_t bq[$];
    s_exp_t sq[$];
    logic [31:0] ref_mem [int];
    logic [31:0] wd [16];
    logic [3:0]  ws [16];

    int checks = 0;
    int errors = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout expected handshake", name);
    endtask

    function automatic int word_of(logic [31:0] a);
        logic [31:0] w;
        w = ((a - BASE) >> 2) & ((32'd1 << MEM_AW) - 1);
        return int'(w);
    endfunction

    function automatic bit out_of_window(logic [31:0] a);
        return RC && ((a - BASE) >= (32'd4 << MEM_AW));
    endfunction

    function automatic logic [31:0] ref_get(int w);
        return ref_mem.exists(w) ? ref_mem[w] : 32'h0;
    endfunction

    task automatic push_read(logic [3:0] id, logic [31:0] addr, int len, logic [2:0] size, logic [1:0] burst);
        logic [31:0] a;
        bit e;
        int w;
        a = addr;
        e = out_of_window(addr);
        for (int i = 0; i <= len; i++) begin
            w = word_of(a);
            rq.push_back('{id, e ? 32'h0 : ref_get(w), e ? 2'b10 : 2'b00, i == len});
            if (!e) sq.push_back('{4'b0000, w[MEM_AW-1:0], 32'h0});
            if (burst != 2'b00) a = a + (32'd1 << size);
        end
    endtask

    task automatic push_write(logic [3:0] id, logic [31:0] addr, int len, logic [2:0] size, logic [1:0] burst);
        logic [31:0] a, v;
        bit e;
        int w;
        a = addr;
        e = out_of_window(addr);
        for (int i = 0; i <= len; i++) begin
            w = word_of(a);
            if (!e) begin
                v = ref_get(w);
                for (int b = 0; b < 4; b++)
                    if (ws[i][b]) v[8*b +: 8] = wd[i][8*b +: 8];
                ref_mem[w] = v;
                sq.push_back('{ws[i], w[MEM_AW-1:0], wd[i]});
            end
            if (burst != 2'b00) a = a + (32'd1 << size);
        end
        bq.push_back('{id, e ? 2'b10 : 2'b00});
    endtask

    // scoreboard monitor, sampling on the falling edge
    r_exp_t re;
    b_exp_t be;
    s_exp_t se;
    logic        r_held;
    logic [31:0] r_held_data;
    initial r_held = 1'b0;
    always @(negedge aclk) begin
        if (aresetn) begin
            if (rvalid && r_held) chk("r_stable", rdata, r_held_data);
            r_held      = rvalid && !rready;
            r_held_data = rdata;
            if (rvalid && rready) begin
                if (rq.size() == 0) chk("r_unexpected", 32'd1, 32'd0);
                else begin
                    re = rq.pop_front();
                    chk("rdata", rdata, re.data);
                    chk("rid", 32'(rid), 32'(re.id));
                    chk("rresp", 32'(rresp), 32'(re.resp));
                    chk("rlast", 32'(rlast), 32'(re.last));
                end
            end
            if (bvalid && bready) begin
                if (bq.size() == 0) chk("b_unexpected", 32'd1, 32'd0);
                else begin
                    be = bq.pop_front();
                    chk("bid", 32'(bid), 32'(be.id));
                    chk("bresp", 32'(bresp), 32'(be.resp));
                end
            end
            if (sram_en) begin
                if (sq.size() == 0) chk("sram_unexpected", 32'd1, 32'd0);
                else begin
                    se = sq.pop_front();
                    chk("sram_we", 32'(sram_we), 32'(se.we));
                    chk("sram_addr", 32'(sram_addr), 32'(se.addr));
                    if (se.we != 4'b0000) chk("sram_wdata", sram_wdata, se.wdata);
                end
            end
        end else begin
            r_held = 1'b0;
        end
    end

    task automatic wait_ar();
        int n = 0;
        bit ok = 0;
        while (!ok && n < 100) begin
            @(negedge aclk); ok = arready;
            @(posedge aclk); n++;
        end
        #1;
        if (!ok) timeout("ar_handshake");
    endtask

    task automatic wait_aw();
        int n = 0;
        bit ok = 0;
        while (!ok && n < 100) begin
            @(negedge aclk); ok = awready;
            @(posedge aclk); n++;
        end
        #1;
        if (!ok) timeout("aw_handshake");
    endtask

    task automatic r_recv(int len, int stall_beat, int stall);
        int beat = 0;
        int n = 0;
        bit hs;
        rready = (stall_beat != 0);
        while (beat <= len && n < 400) begin
            @(negedge aclk); n++;
            if (rvalid && !rready) begin
                repeat (stall + 1) @(posedge aclk);
                #1 rready = 1'b1;
            end else begin
                hs = rvalid && rready;
                @(posedge aclk); #1;
                if (hs) begin
                    beat++;
                    if (beat == stall_beat) rready = 1'b0;
                end
            end
        end
        rready = 1'b1;
        if (beat <= len) timeout("r_beats");
    endtask

    task automatic w_send(int len);
        int n;
        bit ok;
        for (int i = 0; i <= len; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                wvalid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge aclk);
                #1;
            end
            wvalid = 1'b1; wdata = wd[i]; wstrb = ws[i]; wlast = (i == len); wid = 4'($urandom);
            n = 0; ok = 0;
            while (!ok && n < 100) begin
                @(negedge aclk); ok = wready;
                @(posedge aclk); n++;
            end
            #1;
            if (!ok) timeout("w_beat");
        end
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic b_recv(int delay);
        int n = 0;
        bit ok = 0;
        bready = 1'b0;
        repeat (delay) @(posedge aclk);
        #1 bready = 1'b1;
        while (!ok && n < 100) begin
            @(negedge aclk); ok = bvalid;
            @(posedge aclk); n++;
        end
        #1;
        if (!ok) timeout("b_handshake");
    endtask

    task automatic fill_w(int len, bit rnd_strb);
        for (int i = 0; i <= len; i++) begin
            wd[i] = $urandom;
            ws[i] = rnd_strb ? 4'($urandom_range(1, 15)) : 4'hF;
        end
    endtask

    task automatic do_read(logic [3:0] id, logic [31:0] addr, int len, logic [2:0] size,
                           logic [1:0] burst, int stall_beat, int stall);
        push_read(id, addr, len, size, burst);
        arid = id; araddr = addr; arlen = 4'(len); arsize = size; arburst = burst; arvalid = 1'b1;
        wait_ar();
        arvalid = 1'b0;
        r_recv(len, stall_beat, stall);
    endtask

    task automatic do_write(logic [3:0] id, logic [31:0] addr, int len, logic [2:0] size, logic [1:0] burst);
        push_write(id, addr, len, size, burst);
        awid = id; awaddr = addr; awlen = 4'(len); awsize = size; awburst = burst; awvalid = 1'b1;
        wait_aw();
        awvalid = 1'b0;
        w_send(len);
        b_recv($urandom_range(0, 3));
    endtask

    initial begin
        aresetn = 1'b0; sram_rdata = 32'h0;
        arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; arvalid = 0; rready = 1;
        awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0; awvalid = 0;
        wid = 0; wdata = 0; wstrb = 0; wlast = 0; wvalid = 0; bready = 1;
        sram_mem[16] = 32'hDEADBEEF;
        ref_mem[16]  = 32'hDEADBEEF;

        @(negedge aclk);
        chk("rst_arready", 32'(arready), 0);
        chk("rst_awready", 32'(awready), 0);
        chk("rst_rvalid", 32'(rvalid), 0);
        chk("rst_bvalid", 32'(bvalid), 0);
        chk("rst_wready", 32'(wready), 0);
        chk("rst_sram", {27'd0, sram_en, sram_we}, 0);
        chk("rst_rpayload", rdata | 32'(rid) | 32'(rresp) | 32'(rlast), 0);
        chk("rst_bpayload", 32'(bid) | 32'(bresp), 0);
        @(posedge aclk); #1 aresetn = 1'b1;
        @(posedge aclk); #1;

        // simultaneous AR/AW: read wins first, then the pending write beats a new AR
        push_read(4'd3, 32'h40, 0, 3'd2, 2'b01);
        wd[0] = 32'h11223344; ws[0] = 4'b0010;
        push_write(4'd5, 32'h8, 0, 3'd2, 2'b01);
        push_read(4'd7, 32'h8, 0, 3'd2, 2'b01);
        arid = 3; araddr = 32'h40; arlen = 0; arsize = 2; arburst = 1; arvalid = 1;
        awid = 5; awaddr = 32'h8;  awlen = 0; awsize = 2; awburst = 1; awvalid = 1;
        @(negedge aclk);
        chk("arb1_arready", 32'(arready), 1);
        chk("arb1_awready", 32'(awready), 0);
        @(posedge aclk); #1;
        arid = 7; araddr = 32'h8;
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            chk("r_latency", 32'(rvalid), 32'(i == 2));
        end
        @(posedge aclk); #1;
        @(negedge aclk);
        chk("arb2_awready", 32'(awready), 1);
        chk("arb2_arready", 32'(arready), 0);
        @(posedge aclk); #1 awvalid = 1'b0;
        w_send(0);
        b_recv(2);
        wait_ar();
        arvalid = 1'b0;
        r_recv(0, 16, 0);

        do_read(4'd1, 32'h100, 3, 3'd2, 2'b01, 1, 5);
        fill_w(2, 1'b0);
        do_write(4'd2, 32'h20, 2, 3'd2, 2'b00);
        do_read(4'd4, 32'h20, 0, 3'd2, 2'b01, 16, 0);
        do_read(4'd6, 32'h0004_0000, 1, 3'd2, 2'b01, 16, 0);

        for (int t = 0; t < 40; t++) begin
            logic [31:0] a;
            int len;
            a   = 32'($urandom_range(0, 'h3FF)) | (($urandom_range(0, 3) == 0) ? 32'h0004_0000 : 32'h0);
            len = $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 1) begin
                fill_w(len, 1'b1);
                do_write(4'($urandom), a, len, 3'($urandom_range(0, 2)), 2'($urandom_range(0, 3)));
            end else begin
                do_read(4'($urandom), a, len, 3'($urandom_range(0, 2)), 2'($urandom_range(0, 3)),
                        $urandom_range(0, len), $urandom_range(0, 3));
            end
        end

        // reset in the middle of a read burst drops the rest of it
        push_read(4'd9, 32'h200, 3, 3'd2, 2'b01);
        arid = 9; araddr = 32'h200; arlen = 3; arsize = 2; arburst = 1; arvalid = 1;
        wait_ar();
        arvalid = 1'b0;
        begin
            int n = 0;
            bit ok = 0;
            while (!ok && n < 50) begin
                @(negedge aclk); ok = rvalid;
                @(posedge aclk); n++;
            end
            if (!ok) timeout("mid_burst_beat");
        end
        #1 aresetn = 1'b0;
        rq.delete();
        sq.delete();
        @(negedge aclk);
        chk("abort_rvalid", 32'(rvalid), 0);
        chk("abort_sram_en", 32'(sram_en), 0);
        @(posedge aclk); #1 aresetn = 1'b1;
        repeat (12) begin
            @(negedge aclk);
            chk("abort_quiet", {30'd0, rvalid, sram_en}, 0);
        end

        repeat (4) @(negedge aclk);
        chk("rq_drained", 32'(rq.size()), 0);
        chk("bq_drained", 32'(bq.size()), 0);
        chk("sq_drained", 32'(sq.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
